param_bank: RTL and testbench

Parametrised parameterization interface for the reconfigurable-logic wrapper, the successor to the fixed ParamIntf/ParamOutReg pairing.
- Provides NumWr 16-bit write parameters and NumRd 16-bit read-back values behind one peripheral-bus window.
- Adds pointer auto-increment, shadow registers with atomic commit, and a direct-write mode.
- Sits between the CPU peripheral bus and the application (e.g. sensor FSMs) inside the reconfigurable module.

---
 rtl/param_bank_pkg.sv | 32 +++
 rtl/param_reg_slice.sv | 43 ++++
 rtl/param_bank.sv | 140 ++++++++++++++
 tb/tb_param_bank.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/param_bank_pkg.sv
// Purpose: shared constants and helpers for the param_bank register window.
// Latency: n/a (package only).
// Backpressure: n/a; the peripheral bus has no stall mechanism.
package param_bank_pkg;

    localparam int DATA_W    = 16;
    localparam int NUM_BYTES = DATA_W / 8;

    // Word offsets from the base address.
    localparam logic [13:0] OFS_CTRL = 14'd0;
    localparam logic [13:0] OFS_PTR  = 14'd1;
    localparam logic [13:0] OFS_DATA = 14'd2;

    // CTRL write bit positions.
    localparam int CTRL_COMMIT   = 0;
    localparam int CTRL_SHADOWED = 1;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0]    old_val,
        input logic [DATA_W-1:0]    new_val,
        input logic [NUM_BYTES-1:0] be
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/param_reg_slice.sv
// Purpose: one shadow + active 16-bit parameter pair with byte-lane writes.
// Latency: shadow/active update at the write edge, visible next cycle.
// Backpressure: none; every strobe is accepted in the cycle it arrives.
module param_reg_slice
    import param_bank_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_BYTES-1:0] be,
    input  logic [DATA_W-1:0]    din,
    input  logic                 shadow_we,
    input  logic                 direct_we,
    input  logic                 commit,
    output logic [DATA_W-1:0]    active
);

    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] shadow_next;

    assign shadow_next = merge_bytes(shadow, din, be);

    // Shadow copy takes every in-range DATA write, lane by lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (shadow_we) begin
            shadow <= shadow_next;
        end
    end

    // Active copy: commit takes the pre-edge shadow; a direct write mirrors
    // the freshly merged shadow value so both copies stay identical.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= '0;
        end else if (commit) begin
            active <= shadow;
        end else if (direct_we) begin
            active <= shadow_next;
        end
    end

endmodule

// File: rtl/param_bank.sv
// Purpose: peripheral-bus window exposing NumWr shadowed parameters and NumRd read-back words.
// Latency: reads combinational; writes land at the access edge, Params_o/CommitPulse_o next cycle.
// Backpressure: none; the bus is never stalled and unmapped offsets read as 0.
module param_bank
    import param_bank_pkg::*;
#(
    parameter logic [13:0] BaseAddr = 14'h0188,
    parameter int          NumWr    = 5,
    parameter int          NumRd    = 2,
    parameter int          PtrWidth = 6
) (
    input  logic                     Clk_i,
    input  logic                     Reset_n_i,
    input  logic [13:0]              PerAddr_i,
    input  logic [DATA_W-1:0]        PerDIn_i,
    input  logic [1:0]               PerWr_i,
    input  logic                     PerEn_i,
    output logic [DATA_W-1:0]        PerDOut_o,
    output logic [DATA_W*NumWr-1:0]  Params_o,
    input  logic [DATA_W*NumRd-1:0]  ParamsIn_i,
    output logic                     CommitPulse_o,
    output logic                     Pending_o
);

    localparam logic [13:0]     ADDR_CTRL = BaseAddr + OFS_CTRL;
    localparam logic [13:0]     ADDR_PTR  = BaseAddr + OFS_PTR;
    localparam logic [13:0]     ADDR_DATA = BaseAddr + OFS_DATA;
    localparam int              PTR_SPAN  = 2 ** PtrWidth;
    localparam logic [PtrWidth:0] NUM_WR_L = NumWr[PtrWidth:0];

    logic [PtrWidth-1:0] ptr;
    logic                shadowed;
    logic                pending;
    logic                commit_pulse;

    logic is_wr;
    logic sel_ctrl, sel_ptr, sel_data;
    logic ctrl_wr, ptr_wr, data_wr;
    logic commit;
    logic wr_in_range;
    logic direct_wr;

    assign is_wr    = |PerWr_i;
    assign sel_ctrl = PerEn_i && (PerAddr_i == ADDR_CTRL);
    assign sel_ptr  = PerEn_i && (PerAddr_i == ADDR_PTR);
    assign sel_data = PerEn_i && (PerAddr_i == ADDR_DATA);

    assign ctrl_wr     = sel_ctrl && is_wr;
    assign ptr_wr      = sel_ptr && is_wr;
    assign data_wr     = sel_data && is_wr;
    assign commit      = ctrl_wr && PerDIn_i[CTRL_COMMIT];
    assign wr_in_range = data_wr && ({1'b0, ptr} < NUM_WR_L);
    assign direct_wr   = wr_in_range && !shadowed;

    // Pointer: explicit load, otherwise bump on every DATA access (read or write).
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            ptr <= '0;
        end else if (ptr_wr) begin
            ptr <= PerDIn_i[PtrWidth-1:0];
        end else if (sel_data) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Mode and pending flags; a commit clears pending even if a mode change rides along.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            shadowed <= 1'b0;
            pending  <= 1'b0;
        end else begin
            if (ctrl_wr) shadowed <= PerDIn_i[CTRL_SHADOWED];
            if (commit) begin
                pending <= 1'b0;
            end else if (wr_in_range && shadowed) begin
                pending <= 1'b1;
            end
        end
    end

    // One-cycle pulse whenever the active set changes at this edge.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            commit_pulse <= 1'b0;
        end else begin
            commit_pulse <= commit || direct_wr;
        end
    end

    assign CommitPulse_o = commit_pulse;
    assign Pending_o     = pending;

    genvar gi;
    generate
        for (gi = 0; gi < NumWr; gi++) begin : g_slice
            localparam logic [PtrWidth-1:0] IDX = PtrWidth'(gi);
            logic hit;
            assign hit = (ptr == IDX);
            param_reg_slice u_slice (
                .clk       (Clk_i),
                .rst_n     (Reset_n_i),
                .be        (PerWr_i),
                .din       (PerDIn_i),
                .shadow_we (wr_in_range && hit),
                .direct_we (direct_wr && hit),
                .commit    (commit),
                .active    (Params_o[DATA_W*gi +: DATA_W])
            );
        end
    endgenerate

    // Read-back table padded with zeros so any pointer value indexes safely.
    logic [DATA_W-1:0] rd_arr [PTR_SPAN];
    genvar gj;
    generate
        for (gj = 0; gj < PTR_SPAN; gj++) begin : g_rd
            if (gj < NumRd) begin : g_live
                assign rd_arr[gj] = ParamsIn_i[DATA_W*gj +: DATA_W];
            end else begin : g_zero
                assign rd_arr[gj] = '0;
            end
        end
    endgenerate

    // Combinational read mux; anything not a read of a decoded offset returns 0.
    always_comb begin
        PerDOut_o = '0;
        if (!is_wr) begin
            if (sel_ctrl) begin
                PerDOut_o[CTRL_SHADOWED] = shadowed;
                PerDOut_o[0]             = pending;
            end else if (sel_ptr) begin
                PerDOut_o[PtrWidth-1:0] = ptr;
            end else if (sel_data) begin
                PerDOut_o = rd_arr[ptr];
            end
        end
    end

endmodule

// File: tb/tb_param_bank.sv
// Purpose: self-checking bench for param_bank against a behavioural register-map model.
// Latency: each bus access occupies one clock; effects checked one step after the edge.
// Backpressure: n/a; bench drives the bus freely.
module tb_param_bank;

    localparam logic [13:0] BASE = 14'h0188;
    localparam int NW = 5;
    localparam int NR = 2;
    localparam int PW = 6;

    logic              Clk_i = 1'b0;
    logic              Reset_n_i = 1'b0;
    logic [13:0]       PerAddr_i = '0;
    logic [15:0]       PerDIn_i = '0;
    logic [1:0]        PerWr_i = '0;
    logic              PerEn_i = 1'b0;
    logic [15:0]       PerDOut_o;
    logic [16*NW-1:0]  Params_o;
    logic [16*NR-1:0]  ParamsIn_i = '0;
    logic              CommitPulse_o;
    logic              Pending_o;

    param_bank #(.BaseAddr(BASE), .NumWr(NW), .NumRd(NR), .PtrWidth(PW)) dut (
        .Clk_i         (Clk_i),
        .Reset_n_i     (Reset_n_i),
        .PerAddr_i     (PerAddr_i),
        .PerDIn_i      (PerDIn_i),
        .PerWr_i       (PerWr_i),
        .PerEn_i       (PerEn_i),
        .PerDOut_o     (PerDOut_o),
        .Params_o      (Params_o),
        .ParamsIn_i    (ParamsIn_i),
        .CommitPulse_o (CommitPulse_o),
        .Pending_o     (Pending_o)
    );

    always #5 Clk_i = ~Clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of the register map.
    logic [15:0] m_shadow [NW];
    logic [15:0] m_active [NW];
    int          m_ptr;
    bit          m_shadowed;
    bit          m_pending;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic m_reset();
        for (int i = 0; i < NW; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_ptr = 0; m_shadowed = 0; m_pending = 0;
    endtask

    function automatic logic [16*NW-1:0] m_params();
        logic [16*NW-1:0] p;
        for (int i = 0; i < NW; i++) p[16*i +: 16] = m_active[i];
        return p;
    endfunction

    // Apply one access to the model; returns expected read data and pulse.
    task automatic m_access(input logic [13:0] a, input logic [15:0] d, input logic [1:0] w,
                            output logic [15:0] er, output bit ep);
        int ofs;
        ofs = int'(a) - int'(BASE);
        er = '0; ep = 0;
        if (ofs < 0 || ofs > 2) return;
        if (w != 2'b00) begin
            if (ofs == 0) begin
                if (d[0]) begin
                    for (int i = 0; i < NW; i++) m_active[i] = m_shadow[i];
                    m_pending = 0; ep = 1;
                end
                m_shadowed = d[1];
            end else if (ofs == 1) begin
                m_ptr = d % 64;
            end else begin
                if (m_ptr < NW) begin
                    if (w[0]) m_shadow[m_ptr][7:0]  = d[7:0];
                    if (w[1]) m_shadow[m_ptr][15:8] = d[15:8];
                    if (m_shadowed) m_pending = 1;
                    else begin
                        m_active[m_ptr] = m_shadow[m_ptr];
                        ep = 1;
                    end
                end
                m_ptr = (m_ptr + 1) % 64;
            end
        end else begin
            if (ofs == 0) er = {14'd0, m_shadowed, m_pending};
            else if (ofs == 1) er = 16'(m_ptr);
            else begin
                er = (m_ptr < NR) ? ParamsIn_i[16*m_ptr +: 16] : 16'h0;
                m_ptr = (m_ptr + 1) % 64;
            end
        end
    endtask

    task automatic bus(input logic [13:0] a, input logic [15:0] d, input logic [1:0] w,
                       output logic [15:0] r);
        @(negedge Clk_i);
        PerAddr_i = a; PerDIn_i = d; PerWr_i = w; PerEn_i = 1'b1;
        #2;
        r = PerDOut_o;
        @(posedge Clk_i);
        #1;
        PerEn_i = 1'b0; PerWr_i = 2'b00;
    endtask

    logic [15:0] last_rd;

    task automatic op(input string tag, input logic [13:0] a, input logic [15:0] d,
                      input logic [1:0] w);
        logic [15:0] r, er;
        bit ep;
        m_access(a, d, w, er, ep);
        bus(a, d, w, r);
        last_rd = r;
        if (w == 2'b00) check({tag, " rdata"}, 128'(r), 128'(er));
        check({tag, " pulse"}, 128'(CommitPulse_o), 128'(ep));
        check({tag, " params"}, 128'(Params_o), 128'(m_params()));
        check({tag, " pending"}, 128'(Pending_o), 128'(m_pending));
    endtask

    initial begin
        logic [15:0] r;
        m_reset();
        #12;
        check("reset dout", 128'(PerDOut_o), 128'h0);
        check("reset params", 128'(Params_o), 128'h0);
        Reset_n_i = 1'b1;

        // Reset state and unrelated address.
        op("rd ctrl", BASE + 0, 16'h0, 2'b00);
        check("ctrl zero", 128'(last_rd), 128'h0);
        op("unrelated", 14'h0000, 16'h0, 2'b00);
        check("unrelated zero", 128'(last_rd), 128'h0);

        // Direct mode.
        op("ptr0", BASE + 1, 16'h0, 2'b11);
        op("d1234", BASE + 2, 16'h1234, 2'b11);
        op("dabcd", BASE + 2, 16'hABCD, 2'b11);
        check("word0 direct", 128'(Params_o[15:0]), 128'h1234);
        check("word1 direct", 128'(Params_o[31:16]), 128'hABCD);
        op("rd ptr2", BASE + 1, 16'h0, 2'b00);
        check("ptr is 2", 128'(last_rd), 128'h2);

        // Shadowed mode and commit.
        op("ctrl shd", BASE + 0, 16'h0002, 2'b11);
        op("ptr3", BASE + 1, 16'h3, 2'b11);
        op("d5555", BASE + 2, 16'h5555, 2'b11);
        check("word3 held", 128'(Params_o[63:48]), 128'h0);
        op("stat3", BASE + 0, 16'h0, 2'b00);
        check("stat 3", 128'(last_rd), 128'h3);
        op("commit", BASE + 0, 16'h0003, 2'b11);
        check("word3 commit", 128'(Params_o[63:48]), 128'h5555);
        check("commit pulse", 128'(CommitPulse_o), 128'h1);
        op("stat2", BASE + 0, 16'h0, 2'b00);
        check("stat 2", 128'(last_rd), 128'h2);

        // Read-back.
        ParamsIn_i = {16'h00AA, 16'hBEEF};
        op("ptr0 rb", BASE + 1, 16'h0, 2'b11);
        op("rb0", BASE + 2, 16'h0, 2'b00);
        check("rb beef", 128'(last_rd), 128'hBEEF);
        op("rb1", BASE + 2, 16'h0, 2'b00);
        check("rb 00aa", 128'(last_rd), 128'h00AA);
        op("rb2", BASE + 2, 16'h0, 2'b00);
        check("rb oor", 128'(last_rd), 128'h0);
        op("rd ptr3", BASE + 1, 16'h0, 2'b00);
        check("ptr is 3", 128'(last_rd), 128'h3);

        // Out-of-range write, wrap, byte write.
        op("ptr5", BASE + 1, 16'h5, 2'b11);
        op("oor wr", BASE + 2, 16'hFFFF, 2'b11);
        check("oor no pend", 128'(Pending_o), 128'h0);
        op("ptr63", BASE + 1, 16'd63, 2'b11);
        op("rd 63", BASE + 2, 16'h0, 2'b00);
        op("rd ptr wrap", BASE + 1, 16'h0, 2'b00);
        check("ptr wrapped", 128'(last_rd), 128'h0);
        op("ctrl direct", BASE + 0, 16'h0000, 2'b11);
        op("bw", BASE + 2, 16'h77EE, 2'b01);
        check("byte write", 128'(Params_o[15:0]), 128'h12EE);
        op("unmapped", BASE + 3, 16'hFFFF, 2'b11);
        op("unmapped rd", BASE + 3, 16'h0, 2'b00);
        check("unmapped zero", 128'(last_rd), 128'h0);

        // Reset between a shadowed write and its commit.
        op("ctrl shd2", BASE + 0, 16'h0002, 2'b11);
        op("ptr1", BASE + 1, 16'h1, 2'b11);
        op("d9999", BASE + 2, 16'h9999, 2'b11);
        @(negedge Clk_i);
        #2;
        Reset_n_i = 1'b0;
        #1;
        check("async params", 128'(Params_o), 128'h0);
        check("async pending", 128'(Pending_o), 128'h0);
        m_reset();
        @(negedge Clk_i);
        Reset_n_i = 1'b1;
        op("post rst commit", BASE + 0, 16'h0001, 2'b11);
        check("no survivor", 128'(Params_o), 128'h0);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int sel;
            logic [13:0] a;
            logic [15:0] d;
            logic [1:0]  w;
            sel = $urandom_range(0, 99);
            d = 16'($urandom);
            w = 2'($urandom);
            if (sel < 55) a = BASE + 2;
            else if (sel < 72) begin
                a = BASE + 1;
                d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(58, 63))
                                                : 16'($urandom_range(0, 7));
            end else if (sel < 87) begin
                a = BASE + 0;
                d = 16'($urandom_range(0, 3));
            end else if (sel < 95) a = BASE + 14'($urandom_range(3, 6));
            else a = 14'($urandom);
            if ($urandom_range(0, 9) == 0) ParamsIn_i = 32'($urandom);
            op("rand", a, d, w);
        end

        @(negedge Clk_i);
        check("idle dout", 128'(PerDOut_o), 128'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
